// File: rtl/uart_rx_frame.sv
// UART frame receiver: start bit, 8 data bits LSB first, optional parity bit,
// one stop bit. A mid-bit sampling timer supplies bit timing. The received
// byte and sticky status flags are held for the host register interface.
module uart_rx_frame #(
    parameter int DIV_W = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic [DIV_W-1:0] baud_k,
    input  logic             pen,
    input  logic             ohel,
    input  logic             rd_clr,
    output logic [7:0]       rx_data,
    output logic             rdy,
    output logic             perr,
    output logic             ferr,
    output logic             ovf
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             sync1;
    logic             sync2;
    logic             sync_prev;
    logic [DIV_W-1:0] timer;
    logic [3:0]       bitcnt;
    logic [7:0]       shreg;
    logic             par_bit;

    logic             fall;
    logic             strobe;
    logic             complete;
    logic             par_exp;
    logic             par_mis;

    assign fall     = sync_prev & ~sync2;
    assign strobe   = (timer == '0) && (state != IDLE);
    assign complete = strobe && (state == STOP);
    assign par_exp  = ohel ? ~^shreg : ^shreg;
    assign par_mis  = pen && (par_bit != par_exp);

    // Two-stage synchroniser plus previous-value register for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= rx;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; every transition out of a busy state waits on the strobe.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fall) state_nxt = START;
            START:   if (strobe) state_nxt = sync2 ? IDLE : DATA;
            DATA:    if (strobe && (bitcnt == 4'd7)) state_nxt = pen ? PARITY : STOP;
            PARITY:  if (strobe) state_nxt = STOP;
            STOP:    if (strobe) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bit timer: half-bit load on start edge, full-bit reload on every strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (state == IDLE) begin
            if (fall) timer <= (baud_k >> 1) - DIV_W'(1);
        end else if (strobe) begin
            timer <= baud_k - DIV_W'(1);
        end else begin
            timer <= timer - DIV_W'(1);
        end
    end

    // Data shift register, bit counter and parity sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitcnt  <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            if ((state == IDLE) && fall) bitcnt <= '0;
            if ((state == DATA) && strobe) begin
                shreg[bitcnt[2:0]] <= sync2;
                bitcnt             <= bitcnt + 4'd1;
            end
            if ((state == PARITY) && strobe) par_bit <= sync2;
        end
    end

    // Host-visible status: completion overrides a coincident read strobe,
    // in which case only the new frame's flags survive and overrun is clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data <= '0;
            rdy     <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            ovf     <= 1'b0;
        end else if (complete) begin
            rx_data <= shreg;
            rdy     <= 1'b1;
            if (rd_clr) begin
                perr <= par_mis;
                ferr <= ~sync2;
                ovf  <= 1'b0;
            end else begin
                perr <= perr | par_mis;
                ferr <= ferr | ~sync2;
                ovf  <= ovf | rdy;
            end
        end else if (rd_clr) begin
            rdy  <= 1'b0;
            perr <= 1'b0;
            ferr <= 1'b0;
            ovf  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: table of single frames plus
// hand-written sequences for glitch, sticky flags, overrun and reset abort.
module tb_uart_rx_frame;

    localparam int DIV_W = 19;
    localparam int BAUD  = 16;

    logic             clk;
    logic             reset;
    logic             rx;
    logic [DIV_W-1:0] baud_k;
    logic             pen;
    logic             ohel;
    logic             rd_clr;
    logic [7:0]       rx_data;
    logic             rdy;
    logic             perr;
    logic             ferr;
    logic             ovf;

    uart_rx_frame #(.DIV_W(DIV_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .rx     (rx),
        .baud_k (baud_k),
        .pen    (pen),
        .ohel   (ohel),
        .rd_clr (rd_clr),
        .rx_data(rx_data),
        .rdy    (rdy),
        .perr   (perr),
        .ferr   (ferr),
        .ovf    (ovf)
    );

    typedef struct {
        logic [7:0] d;
        bit         p_en;
        bit         odd;
        bit         p_bit;
        bit         stop;
        bit         e_perr;
        bit         e_ferr;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        bit         rdy;
        bit         perr;
        bit         ferr;
        bit         ovf;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   checks = 0;
    int   passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 rd_clr = 1'b1;
        @(posedge clk); #1 rd_clr = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] d, input bit pe, input bit fe, input bit ov);
        exp_t e;
        e.d = d; e.rdy = 1'b1; e.perr = pe; e.ferr = fe; e.ovf = ov;
        sb.push_back(e);
    endtask

    // Drives one frame; rd_clr pulses at clr_cycle and reset is pulsed low
    // at rst_cycle (negative disables), counted in clocks from the start edge.
    task automatic send_frame(input logic [7:0] d, input bit p_bit, input bit stop,
                              input int clr_cycle, input int rst_cycle);
        logic [10:0] fr;
        int          nb;
        nb = pen ? 11 : 10;
        fr = pen ? {stop, p_bit, d, 1'b0} : {1'b1, stop, d, 1'b0};
        @(posedge clk); #1 rx = fr[0];
        for (int c = 1; c < nb * BAUD; c++) begin
            @(posedge clk); #1;
            rx     = fr[c / BAUD];
            rd_clr = (c == clr_cycle);
            if (c == rst_cycle) begin
                reset = 1'b0;
                #1;
                chk("rst_mid.rx_data", rx_data, 8'h00);
                chk("rst_mid.rdy", rdy, 1'b0);
                chk("rst_mid.perr", perr, 1'b0);
                chk("rst_mid.ferr", ferr, 1'b0);
                chk("rst_mid.ovf", ovf, 1'b0);
            end
            if (rst_cycle >= 0 && c == rst_cycle + 4) reset = 1'b1;
        end
        @(posedge clk); #1 rx = 1'b1; rd_clr = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic check_frame(input string tag);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (rdy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (rdy !== 1'b1) begin
            checks++;
            $display("FAIL %s.rdy_wait: got %b expected 1 within 50 clocks", tag, rdy);
        end
        if (sb.size() == 0) begin
            checks++;
            $display("FAIL %s.scoreboard: got empty queue expected one entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".rx_data"}, rx_data, e.d);
            chk({tag, ".rdy"}, rdy, e.rdy);
            chk({tag, ".perr"}, perr, e.perr);
            chk({tag, ".ferr"}, ferr, e.ferr);
            chk({tag, ".ovf"}, ovf, e.ovf);
        end
    endtask

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset  = 1'b0;
        rx     = 1'b1;
        rd_clr = 1'b0;
        baud_k = DIV_W'(BAUD);
        pen    = 1'b0;
        ohel   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.rx_data", rx_data, 8'h00);
        chk("reset.rdy", rdy, 1'b0);
        chk("reset.perr", perr, 1'b0);
        chk("reset.ferr", ferr, 1'b0);
        chk("reset.ovf", ovf, 1'b0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (4) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            pulse_clr();
            pen  = tbl[i].p_en;
            ohel = tbl[i].odd;
            push_exp(tbl[i].d, tbl[i].e_perr, tbl[i].e_ferr, 1'b0);
            send_frame(tbl[i].d, tbl[i].p_bit, tbl[i].stop, -1, -1);
            check_frame($sformatf("vec%0d", i));
        end

        // Flags stay set across a later good frame; the unread byte overruns.
        pen = 1'b0;
        push_exp(8'h42, 1'b0, 1'b1, 1'b1);
        send_frame(8'h42, 1'b0, 1'b1, -1, -1);
        check_frame("sticky");
        pulse_clr();
        @(negedge clk);
        chk("clr.rdy", rdy, 1'b0);
        chk("clr.ferr", ferr, 1'b0);
        chk("clr.ovf", ovf, 1'b0);

        // Short low pulse on the line is rejected as a false start.
        @(posedge clk); #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("glitch.rdy", rdy, 1'b0);
        push_exp(8'h55, 1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, -1, -1);
        check_frame("after_glitch");

        // Overrun, then a read strobe coinciding with completion.
        pulse_clr();
        push_exp(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b1, -1, -1);
        check_frame("ovr_first");
        push_exp(8'h22, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1, -1, -1);
        check_frame("ovr_second");
        push_exp(8'h33, 1'b0, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b1, 154, -1);
        check_frame("clr_at_done");

        // Reset during data bit 4 aborts the frame; the next one is clean.
        send_frame(8'hF0, 1'b0, 1'b1, -1, 88);
        @(negedge clk);
        chk("after_rst.rdy", rdy, 1'b0);
        chk("after_rst.rx_data", rx_data, 8'h00);
        push_exp(8'h0F, 1'b0, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b0, 1'b1, -1, -1);
        check_frame("post_reset");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
